unified_cache_mem_responder: RTL and testbench
==============================================

Name: unified_cache_mem_responder

Overview:
- Synthesizable main-memory responder on the memory side of unified_cache.
- Accepts miss and writeback packets from the cache's to_mem port and returns block fills to the cache's from_mem port, using the same valid/ack packet protocol.
- Backs the cache in FPGA bring-up and replaces hand-written behavioural memory loops in benches.

Parameters:
- UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, packet width; field positions come from the `UNIFIED_CACHE_PACKET_*_POS macros.
- NUM_BLOCKS, 32, number of cache-block-sized memory entries; power of two.
- BLOCK_OFFSET_BITS, 4, low address bits dropped to form the block index.
- LATENCY, 4, cycles from request sample to response/commit; legal range 1..255.

Ports:
- clk_in  input  1  clock
- reset_in  input  1  reset, synchronous, active-low
- request_packet_in  input  UNIFIED_CACHE_PACKET_WIDTH_IN_BITS  packet from cache to_mem_packet_out
- request_packet_ack_out  output  1  one-cycle accept pulse to cache to_mem_packet_ack_in
- response_packet_out  output  UNIFIED_CACHE_PACKET_WIDTH_IN_BITS  fill packet to cache from_mem_packet_in
- response_packet_ack_in  input  1  cache from_mem_packet_ack_out
- read_count_out  output  32  completed reads (only with the optional feature)
- write_count_out  output  32  committed writes (only with the optional feature)

Behaviour:
- Reset (reset_in low at a clk_in edge):
  - state=IDLE, request_packet_ack_out=0, response_packet_out=0, latency counter=0, counters=0.
  - Memory array is not reset.
- Block index = addr[BLOCK_OFFSET_BITS+log2(NUM_BLOCKS)-1 : BLOCK_OFFSET_BITS]. Higher address bits are ignored, so addresses wrap modulo NUM_BLOCKS.
- FSM states:
  - IDLE: if request VALID=1 and request_packet_ack_out=0:
    - latch the full packet;
    - request_packet_ack_out<=1 for exactly one cycle;
    - counter<=LATENCY-1;
    - go to WAIT.
  - WAIT: request_packet_ack_out<=0; request_packet_in is ignored.
    - If counter!=0, decrement.
    - If counter==0 and latched WRITE=1: commit the write (byte i of the entry takes data byte i where BYTE_MASK[i]=1; other bytes unchanged), go to IDLE, no response.
    - If counter==0 and WRITE=0: build the response and go to RESP.
  - RESP: response_packet_out held stable with VALID=1. When response_packet_ack_in=1 at a clock edge: response_packet_out<=0, go to IDLE.
- Response packet fields:
  - ADDR, TYPE, BYTE_MASK, PORT_NUM, CACHEABLE copied from the request;
  - DATA = the full memory entry at the block index;
  - VALID=1, WRITE=0.
- Timing: request sampled at edge 0; ack high in cycle 1; response VALID first visible in cycle LATENCY+1; write committed at edge LATENCY.
- Only one request is outstanding. A VALID request arriving during WAIT or RESP is left pending, unacked, until IDLE.
- A request still VALID in the cycle right after its ack is not re-accepted, because the ack is high in that cycle.
- response_packet_ack_in while not in RESP: ignored.
- Read of an entry whose write commits in the same cycle: not possible, since only one request is outstanding; back-to-back write then read returns the new data.
- Reset mid-operation: returns to IDLE immediately. An uncommitted write is dropped and a pending response is cleared.

Optional Feature:
- Macro: UNIFIED_CACHE_MEM_RESPONDER_STATS_EN.
- Defined:
  - read_count_out increments on each RESP handshake;
  - write_count_out increments on each write commit;
  - both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Write then read: write addr 0x0010, full mask, data 0xA5 pattern; then read addr 0x0010. Expect ack one cycle after each request; read response in cycle LATENCY+1 after its sample with DATA=0xA5 pattern, WRITE=0, VALID=1, PORT_NUM copied.
- Partial write: preload entry 2 with all 0x11; write addr 0x0020 with mask 0x0003, data bytes 0xFF. Read back: bytes 0-1 = 0xFF, remaining bytes = 0x11.
- Wrap-around: write addr 0x0000 value X; read addr (NUM_BLOCKS<<BLOCK_OFFSET_BITS) = 0x0200. Expect X.
- Backpressure: hold response_packet_ack_in=0 for 10 cycles while a second request is VALID. Expect response stable, no second ack; ack the response, then the second request is acked within 2 cycles.
- Reset mid-write: write to entry 5 asserted, reset_in low during WAIT, then read entry 5. Expect old data; ack and response outputs zero during reset.
- With UNIFIED_CACHE_MEM_RESPONDER_STATS_EN: 3 writes and 2 reads give write_count_out=3, read_count_out=2; both read 0 after reset.

Source files
------------

// File: rtl/unified_cache_mem_responder.sv
// rtl/unified_cache_mem_responder.sv - block-granular main memory answering unified_cache miss/writeback packets
// Optional counters: define UNIFIED_CACHE_MEM_RESPONDER_STATS_EN for read_count_out/write_count_out.
`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_ADDR_POS_LO      0
`define UNIFIED_CACHE_PACKET_ADDR_POS_HI      31
`define UNIFIED_CACHE_PACKET_DATA_POS_LO      32
`define UNIFIED_CACHE_PACKET_DATA_POS_HI      159
`define UNIFIED_CACHE_PACKET_TYPE_POS_LO      160
`define UNIFIED_CACHE_PACKET_TYPE_POS_HI      161
`define UNIFIED_CACHE_PACKET_BYTE_MASK_POS_LO 162
`define UNIFIED_CACHE_PACKET_BYTE_MASK_POS_HI 177
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO  178
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI  181
`define UNIFIED_CACHE_PACKET_VALID_POS        182
`define UNIFIED_CACHE_PACKET_WRITE_POS        183
`define UNIFIED_CACHE_PACKET_CACHEABLE_POS    184
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS    185
`endif

module unified_cache_mem_responder #(
  parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
  parameter int NUM_BLOCKS        = 32,
  parameter int BLOCK_OFFSET_BITS = 4,
  parameter int LATENCY           = 4
) (
  input  logic                                          clk_in,
  input  logic                                          reset_in,
  input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] request_packet_in,
  output logic                                          request_packet_ack_out,
  output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] response_packet_out,
  input  logic                                          response_packet_ack_in
`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]                                   read_count_out,
  output logic [31:0]                                   write_count_out
`endif
);

  localparam int PW      = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int ADDR_LO = `UNIFIED_CACHE_PACKET_ADDR_POS_LO;
  localparam int DATA_LO = `UNIFIED_CACHE_PACKET_DATA_POS_LO;
  localparam int DATA_HI = `UNIFIED_CACHE_PACKET_DATA_POS_HI;
  localparam int MASK_LO = `UNIFIED_CACHE_PACKET_BYTE_MASK_POS_LO;
  localparam int MASK_HI = `UNIFIED_CACHE_PACKET_BYTE_MASK_POS_HI;
  localparam int VALID   = `UNIFIED_CACHE_PACKET_VALID_POS;
  localparam int WRITE   = `UNIFIED_CACHE_PACKET_WRITE_POS;
  localparam int DATA_W  = DATA_HI - DATA_LO + 1;
  localparam int MASK_W  = MASK_HI - MASK_LO + 1;
  localparam int IDX_W   = $clog2(NUM_BLOCKS);
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     req_q, req_next, resp_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              ack_next;
  logic              commit;
  logic [DATA_W-1:0] mem [NUM_BLOCKS];
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] entry;
  logic [DATA_W-1:0] merged;

  // Address bits above the index are dropped, so the memory aliases modulo NUM_BLOCKS.
  assign idx   = req_q[ADDR_LO + BLOCK_OFFSET_BITS +: IDX_W];
  assign entry = mem[idx];

  always_comb begin
    merged = entry;
    for (int i = 0; i < MASK_W; i++) begin
      if (req_q[MASK_LO + i]) merged[i*8 +: 8] = req_q[DATA_LO + i*8 +: 8];
    end
  end

  always_comb begin
    state_next = state;
    req_next   = req_q;
    cnt_next   = cnt;
    ack_next   = 1'b0;
    resp_next  = response_packet_out;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        // The ack term keeps a request still held in the ack cycle from being taken twice.
        if (request_packet_in[VALID] && !request_packet_ack_out) begin
          req_next   = request_packet_in;
          ack_next   = 1'b1;
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (req_q[WRITE]) begin
          commit     = 1'b1;
          state_next = IDLE;
        end else begin
          resp_next                  = req_q;
          resp_next[DATA_HI:DATA_LO] = entry;
          resp_next[VALID]           = 1'b1;
          resp_next[WRITE]           = 1'b0;
          state_next                 = RESP;
        end
      end
      RESP: begin
        if (response_packet_ack_in) begin
          resp_next  = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state                  <= IDLE;
      req_q                  <= '0;
      cnt                    <= '0;
      request_packet_ack_out <= 1'b0;
      response_packet_out    <= '0;
    end else begin
      state                  <= state_next;
      req_q                  <= req_next;
      cnt                    <= cnt_next;
      request_packet_ack_out <= ack_next;
      response_packet_out    <= resp_next;
    end
  end

  // Array has no reset; a write still waiting when reset hits is simply lost.
  always_ff @(posedge clk_in) begin
    if (commit && reset_in) mem[idx] <= merged;
  end

`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      read_count_out  <= '0;
      write_count_out <= '0;
    end else begin
      if (state == RESP && response_packet_ack_in && read_count_out != 32'hFFFF_FFFF)
        read_count_out <= read_count_out + 32'd1;
      if (commit && write_count_out != 32'hFFFF_FFFF)
        write_count_out <= write_count_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unified_cache_mem_responder.sv
// tb/tb_unified_cache_mem_responder.sv - randomized bench with transaction-level memory model
`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_ADDR_POS_LO      0
`define UNIFIED_CACHE_PACKET_ADDR_POS_HI      31
`define UNIFIED_CACHE_PACKET_DATA_POS_LO      32
`define UNIFIED_CACHE_PACKET_DATA_POS_HI      159
`define UNIFIED_CACHE_PACKET_TYPE_POS_LO      160
`define UNIFIED_CACHE_PACKET_TYPE_POS_HI      161
`define UNIFIED_CACHE_PACKET_BYTE_MASK_POS_LO 162
`define UNIFIED_CACHE_PACKET_BYTE_MASK_POS_HI 177
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO  178
`define UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI  181
`define UNIFIED_CACHE_PACKET_VALID_POS        182
`define UNIFIED_CACHE_PACKET_WRITE_POS        183
`define UNIFIED_CACHE_PACKET_CACHEABLE_POS    184
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS    185
`endif
`timescale 1ns/1ps

module tb_unified_cache_mem_responder;
  localparam int PW   = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int NB   = 32;
  localparam int OB   = 4;
  localparam int LAT  = 4;
  localparam int A_LO = `UNIFIED_CACHE_PACKET_ADDR_POS_LO;
  localparam int A_HI = `UNIFIED_CACHE_PACKET_ADDR_POS_HI;
  localparam int D_LO = `UNIFIED_CACHE_PACKET_DATA_POS_LO;
  localparam int D_HI = `UNIFIED_CACHE_PACKET_DATA_POS_HI;
  localparam int T_LO = `UNIFIED_CACHE_PACKET_TYPE_POS_LO;
  localparam int T_HI = `UNIFIED_CACHE_PACKET_TYPE_POS_HI;
  localparam int M_LO = `UNIFIED_CACHE_PACKET_BYTE_MASK_POS_LO;
  localparam int M_HI = `UNIFIED_CACHE_PACKET_BYTE_MASK_POS_HI;
  localparam int P_LO = `UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO;
  localparam int P_HI = `UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI;
  localparam int V_B  = `UNIFIED_CACHE_PACKET_VALID_POS;
  localparam int W_B  = `UNIFIED_CACHE_PACKET_WRITE_POS;
  localparam int C_B  = `UNIFIED_CACHE_PACKET_CACHEABLE_POS;
  localparam int DW   = D_HI - D_LO + 1;
  localparam int MW   = M_HI - M_LO + 1;

  logic          clk_in = 1'b0;
  logic          reset_in = 1'b0;
  logic [PW-1:0] request_packet_in = '0;
  logic          request_packet_ack_out;
  logic [PW-1:0] response_packet_out;
  logic          response_packet_ack_in = 1'b0;
`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
  logic [31:0]   read_count_out, write_count_out;
`endif

  unified_cache_mem_responder #(
    .NUM_BLOCKS(NB), .BLOCK_OFFSET_BITS(OB), .LATENCY(LAT)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .request_packet_in(request_packet_in),
    .request_packet_ack_out(request_packet_ack_out),
    .response_packet_out(response_packet_out),
    .response_packet_ack_in(response_packet_ack_in)
`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
    ,
    .read_count_out(read_count_out),
    .write_count_out(write_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;
  int edge_no = 0;
  int ack_mode = 0;

  // Transaction-level model: one request at a time, finishing LAT edges after its sample edge.
  logic [DW-1:0] mmem [NB];
  bit            m_init = 1'b0;
  bit            m_ack = 1'b0;
  bit            m_busy = 1'b0;
  bit            m_rvalid = 1'b0;
  bit            m_nack;
  logic [PW-1:0] m_req = '0;
  logic [PW-1:0] m_resp = '0;
  int            m_due = 0;
  int            m_hs_edge = 0;
  int            m_rd = 0;
  int            m_wr = 0;

  function automatic int blk(input logic [31:0] a);
    return int'((a >> OB) % NB);
  endfunction

  always @(posedge clk_in) begin
    edge_no++;
    if (!reset_in) begin
      m_init = 1'b1; m_ack = 1'b0; m_busy = 1'b0; m_rvalid = 1'b0;
      m_resp = '0; m_rd = 0; m_wr = 0;
    end else if (m_init) begin
      m_nack = 1'b0;
      if (m_rvalid) begin
        if (response_packet_ack_in) begin
          m_rvalid = 1'b0; m_resp = '0; m_rd++; m_hs_edge = edge_no;
        end
      end else if (m_busy) begin
        if (edge_no == m_due) begin
          m_busy = 1'b0;
          if (m_req[W_B]) begin
            for (int i = 0; i < MW; i++)
              if (m_req[M_LO+i]) mmem[blk(m_req[A_HI:A_LO])][i*8 +: 8] = m_req[D_LO + i*8 +: 8];
            m_wr++;
          end else begin
            m_resp            = m_req;
            m_resp[D_HI:D_LO] = mmem[blk(m_req[A_HI:A_LO])];
            m_resp[V_B]       = 1'b1;
            m_resp[W_B]       = 1'b0;
            m_rvalid          = 1'b1;
          end
        end
      end else if (request_packet_in[V_B] && !m_ack) begin
        m_req = request_packet_in; m_busy = 1'b1; m_due = edge_no + LAT; m_nack = 1'b1;
      end
      m_ack = m_nack;
    end
  end

  always @(negedge clk_in) begin
    if (m_init) begin
      vectors++;
      if (request_packet_ack_out !== m_ack) begin
        miscompares++;
        $display("FAIL ack edge=%0d got=%b exp=%b", edge_no, request_packet_ack_out, m_ack);
      end
      vectors++;
      if (response_packet_out !== m_resp) begin
        miscompares++;
        $display("FAIL resp edge=%0d got=%h exp=%h", edge_no, response_packet_out, m_resp);
      end
`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
      vectors++;
      if (read_count_out !== 32'(m_rd) || write_count_out !== 32'(m_wr)) begin
        miscompares++;
        $display("FAIL stats edge=%0d got=%0d/%0d exp=%0d/%0d", edge_no, read_count_out, write_count_out, m_rd, m_wr);
      end
`endif
    end
  end

  always @(negedge clk_in) begin
    case (ack_mode)
      0:       response_packet_ack_in = ($urandom_range(0, 2) == 0);
      1:       response_packet_ack_in = 1'b0;
      default: response_packet_ack_in = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] addr, input bit wr, input logic [MW-1:0] mask,
                      input logic [DW-1:0] data, input logic [3:0] port, input bit hold,
                      output int ack_edge);
    logic [PW-1:0] p;
    p = '0;
    p[A_HI:A_LO] = addr; p[D_HI:D_LO] = data; p[M_HI:M_LO] = mask;
    p[T_HI:T_LO] = 2'($urandom_range(0, 3)); p[P_HI:P_LO] = port;
    p[C_B] = 1'($urandom_range(0, 1)); p[W_B] = wr; p[V_B] = 1'b1;
    @(negedge clk_in);
    request_packet_in = p;
    ack_edge = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (request_packet_ack_out === 1'b1) begin ack_edge = edge_no; break; end
    end
    if (hold) @(negedge clk_in);
    request_packet_in = '0;
    if (ack_edge < 0) chk("req_ack_timeout", 256'(0), 256'(1));
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      if (!m_busy && !m_rvalid) begin done = 1'b1; break; end
    end
    if (!done) chk("idle_timeout", 256'(0), 256'(1));
  endtask

  task automatic rd(input logic [31:0] addr, input logic [3:0] port, output logic [PW-1:0] pkt,
                    output int lat);
    int a, r;
    send(addr, 1'b0, '1, '0, port, 1'b0, a);
    r = -1; pkt = '0;
    for (int i = 0; i < 100; i++) begin
      if (response_packet_out[V_B] === 1'b1) begin r = edge_no; pkt = response_packet_out; break; end
      @(negedge clk_in);
    end
    lat = r - a;
    wait_idle();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [MW-1:0] mask, input logic [DW-1:0] data);
    int a;
    send(addr, 1'b1, mask, data, 4'($urandom_range(0, 15)), 1'b0, a);
    wait_idle();
  endtask

  logic [PW-1:0] pkt;
  logic [DW-1:0] x, old5;
  int lat, a;

  initial begin
    repeat (3) @(negedge clk_in);
    chk("reset_ack", 256'(request_packet_ack_out), 256'(0));
    chk("reset_resp", 256'(response_packet_out), 256'(0));
    reset_in = 1'b1;

    for (int b = 0; b < NB; b++)
      wr(32'(b << OB), '1, {$urandom, $urandom, $urandom, $urandom});

    wr(32'h0010, '1, {16{8'hA5}});
    rd(32'h0010, 4'h9, pkt, lat);
    chk("a5_data", 256'(pkt[D_HI:D_LO]), 256'({16{8'hA5}}));
    chk("a5_flags", 256'({pkt[V_B], pkt[W_B], pkt[P_HI:P_LO]}), 256'({1'b1, 1'b0, 4'h9}));
    chk("read_latency", 256'(lat), 256'(LAT));

    wr(32'h0020, '1, {16{8'h11}});
    wr(32'h0020, 16'h0003, {16{8'hFF}});
    rd(32'h0020, 4'h3, pkt, lat);
    chk("partial_data", 256'(pkt[D_HI:D_LO]), 256'({{14{8'h11}}, 16'hFFFF}));

    x = {$urandom, $urandom, $urandom, $urandom};
    wr(32'h0000, '1, x);
    rd(32'h0200, 4'h1, pkt, lat);
    chk("wrap_data", 256'(pkt[D_HI:D_LO]), 256'(x));

    // Backpressure: response held while a second request waits unacked.
    ack_mode = 1;
    send(32'h0030, 1'b0, '1, '0, 4'h2, 1'b0, a);
    for (int i = 0; i < 20 && response_packet_out[V_B] !== 1'b1; i++) @(negedge clk_in);
    pkt = response_packet_out;
    request_packet_in = '0;
    request_packet_in[A_HI:A_LO] = 32'h0040; request_packet_in[M_HI:M_LO] = '1;
    request_packet_in[W_B] = 1'b1; request_packet_in[V_B] = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (request_packet_ack_out === 1'b1 || response_packet_out !== pkt) lat++;
    end
    chk("bp_stable_noack", 256'(lat), 256'(0));
    ack_mode = 2;
    a = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (request_packet_ack_out === 1'b1) begin a = edge_no; break; end
    end
    request_packet_in = '0;
    ack_mode = 0;
    chk("bp_second_ack", 256'(a - m_hs_edge >= 1 && a - m_hs_edge <= 2), 256'(1));
    wait_idle();

    old5 = {$urandom, $urandom, $urandom, $urandom};
    wr(32'h0050, '1, old5);
    send(32'h0050, 1'b1, '1, ~old5, 4'h0, 1'b0, a);
    @(negedge clk_in);
    reset_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst_ack", 256'(request_packet_ack_out), 256'(0));
    chk("rst_resp", 256'(response_packet_out), 256'(0));
    reset_in = 1'b1;
    rd(32'h0050, 4'h5, pkt, lat);
    chk("rst_old_data", 256'(pkt[D_HI:D_LO]), 256'(old5));

`ifdef UNIFIED_CACHE_MEM_RESPONDER_STATS_EN
    @(negedge clk_in); reset_in = 1'b0;
    @(negedge clk_in); reset_in = 1'b1;
    chk("stats_rst_rd", 256'(read_count_out), 256'(0));
    chk("stats_rst_wr", 256'(write_count_out), 256'(0));
    for (int i = 0; i < 3; i++) wr(32'(i << OB), '1, {4{$urandom}});
    for (int i = 0; i < 2; i++) rd(32'(i << OB), 4'h0, pkt, lat);
    chk("stats_rd", 256'(read_count_out), 256'(2));
    chk("stats_wr", 256'(write_count_out), 256'(3));
`endif

    for (int n = 0; n < 60; n++) begin
      send(32'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)), MW'($urandom),
           {$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), a);
      wait_idle();
    end

    repeat (3) @(negedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
